// File: rtl/bvh_traverser.sv
// Depth-first BVH traversal engine: fetches nodes, drives the ray/box
// intersector, keeps deferred right children on a LIFO and streams hit leaves.
module bvh_traverser #(
    parameter int unsigned NODE_AW     = 10,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ray_valid,
    output logic               ray_ready,
    input  logic [71:0]        ray_orig_in,
    input  logic [71:0]        inv_dir_in,
    input  logic [47:0]        t_range_in,
    output logic               node_rd_en,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [143:0]       node_box,
    input  logic               node_leaf,
    input  logic [NODE_AW-1:0] node_child,
    output logic [71:0]        isect_orig,
    output logic [71:0]        isect_inv_dir,
    output logic [143:0]       isect_box,
    output logic [47:0]        isect_range,
    input  logic               isect_hit,
    input  logic [47:0]        isect_range_out,
    output logic               leaf_valid,
    input  logic               leaf_ready,
    output logic [NODE_AW-1:0] leaf_prim,
    output logic [47:0]        leaf_range,
    output logic               done,
    output logic               overflow,
    output logic [CNT_W-1:0]   nodes_visited
);

    localparam int unsigned VEC3_W = 72;
    localparam int unsigned VEC2_W = 48;
    localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W   = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_TEST,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state;
    logic [VEC3_W-1:0]   ray_orig;
    logic [VEC3_W-1:0]   ray_inv_dir;
    logic [VEC2_W-1:0]   ray_range;
    logic [SP_W-1:0]     sp;
    logic [NODE_AW-1:0]  stack_mem [STACK_DEPTH];

    logic                sp_full;
    logic                sp_empty;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic [NODE_AW-1:0]  right_child;
    logic                push_ok;
    logic                cnt_sat;

    // Stack bookkeeping and the wrapped right-child index
    always_comb begin
        sp_full     = (sp == SP_W'(STACK_DEPTH));
        sp_empty    = (sp == '0);
        push_idx    = IDX_W'(sp);
        top_idx     = IDX_W'(sp - SP_W'(1));
        right_child = node_child + NODE_AW'(1);
        push_ok     = (state == S_TEST) && isect_hit && !node_leaf && !sp_full;
        cnt_sat     = &nodes_visited;
    end

    // Intersector operands: ray values are held for the whole traversal
    assign isect_orig    = ray_orig;
    assign isect_inv_dir = ray_inv_dir;
    assign isect_range   = ray_range;
    assign isect_box     = node_box;

    // Deferred-node storage; contents are only meaningful below sp
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[push_idx] <= right_child;
        end
    end

    // Traversal FSM with registered outputs; node_addr doubles as the current node
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ray_ready     <= 1'b1;
            node_rd_en    <= 1'b0;
            node_addr     <= '0;
            leaf_valid    <= 1'b0;
            leaf_prim     <= '0;
            leaf_range    <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            nodes_visited <= '0;
            sp            <= '0;
            ray_orig      <= '0;
            ray_inv_dir   <= '0;
            ray_range     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ray_valid && ray_ready) begin
                        ray_orig      <= ray_orig_in;
                        ray_inv_dir   <= inv_dir_in;
                        ray_range     <= t_range_in;
                        node_addr     <= '0;
                        sp            <= '0;
                        overflow      <= 1'b0;
                        nodes_visited <= '0;
                        ray_ready     <= 1'b0;
                        node_rd_en    <= 1'b1;
                        state         <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    node_rd_en <= 1'b0;
                    state      <= S_TEST;
                end
                S_TEST: begin
                    if (!cnt_sat) begin
                        nodes_visited <= nodes_visited + CNT_W'(1);
                    end
                    if (isect_hit && !node_leaf) begin
                        if (sp_full) begin
                            overflow <= 1'b1;
                        end else begin
                            sp <= sp + SP_W'(1);
                        end
                        node_addr  <= node_child;
                        node_rd_en <= 1'b1;
                        state      <= S_FETCH;
                    end else if (isect_hit) begin
                        leaf_prim  <= node_child;
                        leaf_range <= isect_range_out;
                        leaf_valid <= 1'b1;
                        state      <= S_EMIT;
                    end else if (!sp_empty) begin
                        node_addr  <= stack_mem[top_idx];
                        sp         <= sp - SP_W'(1);
                        node_rd_en <= 1'b1;
                        state      <= S_FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_EMIT: begin
                    if (leaf_ready) begin
                        leaf_valid <= 1'b0;
                        if (!sp_empty) begin
                            node_addr  <= stack_mem[top_idx];
                            sp         <= sp - SP_W'(1);
                            node_rd_en <= 1'b1;
                            state      <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    ray_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bvh_traverser.sv
// Scoreboard bench for bvh_traverser: a tree in a behavioural node memory,
// a toy intersector keyed on box bit 0, and a DFS reference model.
module tb_bvh_traverser;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;
    localparam int unsigned NMEM  = 1 << AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ray_valid = 1'b0;
    logic           ray_ready;
    logic [71:0]    ray_orig_in = '0;
    logic [71:0]    inv_dir_in = '0;
    logic [47:0]    t_range_in = '0;
    logic           node_rd_en;
    logic [AW-1:0]  node_addr;
    logic [143:0]   node_box = '0;
    logic           node_leaf = 1'b0;
    logic [AW-1:0]  node_child = '0;
    logic [71:0]    isect_orig;
    logic [71:0]    isect_inv_dir;
    logic [143:0]   isect_box;
    logic [47:0]    isect_range;
    logic           isect_hit;
    logic [47:0]    isect_range_out;
    logic           leaf_valid;
    logic           leaf_ready = 1'b1;
    logic [AW-1:0]  leaf_prim;
    logic [47:0]    leaf_range;
    logic           done;
    logic           overflow;
    logic [CW-1:0]  nodes_visited;

    bvh_traverser #(.NODE_AW(AW), .STACK_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_orig_in(ray_orig_in), .inv_dir_in(inv_dir_in), .t_range_in(t_range_in),
        .node_rd_en(node_rd_en), .node_addr(node_addr),
        .node_box(node_box), .node_leaf(node_leaf), .node_child(node_child),
        .isect_orig(isect_orig), .isect_inv_dir(isect_inv_dir),
        .isect_box(isect_box), .isect_range(isect_range),
        .isect_hit(isect_hit), .isect_range_out(isect_range_out),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready),
        .leaf_prim(leaf_prim), .leaf_range(leaf_range),
        .done(done), .overflow(overflow), .nodes_visited(nodes_visited)
    );

    always #5 clk = ~clk;

    // Node memory contents
    logic [143:0]  mem_box   [NMEM];
    logic          mem_leaf  [NMEM];
    logic [AW-1:0] mem_child [NMEM];

    // Toy intersector: hit flag lives in box bit 0, clipped range mixes box and ray range
    assign isect_hit       = isect_box[0];
    assign isect_range_out = isect_box[47:0] ^ isect_range;

    // Node memory with one cycle of read latency
    always @(posedge clk) begin
        if (node_rd_en) begin
            node_box   <= mem_box[node_addr];
            node_leaf  <= mem_leaf[node_addr];
            node_child <= mem_child[node_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0]  exp_addr [$];
    logic [57:0]    exp_leaf [$];
    logic [16:0]    exp_done [$];
    logic [71:0]    cur_orig;
    logic [71:0]    cur_dir;
    int             hold_low = 0;
    bit             mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_node(input int idx, input bit leaf, input int child, input bit hit);
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        mem_box[idx]   = {r[143:1], hit};
        mem_leaf[idx]  = leaf;
        mem_child[idx] = AW'(child);
    endtask

    // Random tree: nodes allocated breadth-first, children always at fresh indices
    task automatic gen_tree(input int limit);
        int nxt;
        nxt = 1;
        for (int i = 0; i < nxt; i++) begin
            if (nxt + 2 <= limit && $urandom_range(0, 9) < 6) begin
                set_node(i, 1'b0, nxt, $urandom_range(0, 3) != 0);
                nxt += 2;
            end else begin
                set_node(i, 1'b1, $urandom_range(0, NMEM - 1), $urandom_range(0, 3) != 0);
            end
        end
    endtask

    // Reference: depth-first walk with a bounded LIFO, recording what must appear
    task automatic model(input logic [47:0] rng);
        logic [AW-1:0] stk [$];
        logic [AW-1:0] cur;
        int            vis;
        bit            ovf;
        cur = '0;
        vis = 0;
        ovf = 1'b0;
        for (int guard = 0; guard < 10000; guard++) begin
            exp_addr.push_back(cur);
            if (vis < 65535) vis++;
            if (mem_box[cur][0] && !mem_leaf[cur]) begin
                if (stk.size() < DEPTH) stk.push_back(mem_child[cur] + AW'(1));
                else ovf = 1'b1;
                cur = mem_child[cur];
                continue;
            end
            if (mem_box[cur][0]) exp_leaf.push_back({mem_child[cur], mem_box[cur][47:0] ^ rng});
            if (stk.size() == 0) break;
            cur = stk.pop_back();
        end
        exp_done.push_back({ovf, 16'(vis)});
    endtask

    // Offer a ray for one cycle once the traverser is idle
    task automatic send_ray(input logic [47:0] rng);
        int w;
        w = 0;
        while (!ray_ready && w < 5000) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        chk("ray_ready_idle", 128'(ray_ready), 128'(1));
        cur_orig    = {$urandom, $urandom, $urandom};
        cur_dir     = {$urandom, $urandom, $urandom};
        ray_orig_in = cur_orig;
        inv_dir_in  = cur_dir;
        t_range_in  = rng;
        model(rng);
        ray_valid   = 1'b1;
        @(posedge clk);
        #1;
        ray_valid   = 1'b0;
        ray_orig_in = '0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (exp_done.size() != 0 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        chk("done_timeout", 128'(exp_done.size()), 128'(0));
        chk("leaf_left", 128'(exp_leaf.size()), 128'(0));
        chk("addr_left", 128'(exp_addr.size()), 128'(0));
    endtask

    // Downstream ready: random, or forced low while hold_low counts down
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low > 0) begin
                leaf_ready = 1'b0;
                hold_low--;
            end else begin
                leaf_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a read, leaf or done
    bit            stalled = 1'b0;
    logic [AW-1:0] st_prim;
    logic [47:0]   st_range;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (stalled) begin
                chk("stall_valid", 128'(leaf_valid), 128'(1));
                chk("stall_prim", 128'(leaf_prim), 128'(st_prim));
                chk("stall_range", 128'(leaf_range), 128'(st_range));
            end
            if (leaf_valid) chk("no_read_in_emit", 128'(node_rd_en), 128'(0));
            if (node_rd_en) begin
                if (exp_addr.size() == 0) chk("unexpected_read", 128'(node_addr), 128'(0) - 1);
                else chk("node_addr", 128'(node_addr), 128'(exp_addr.pop_front()));
                chk("isect_orig", 128'(isect_orig), 128'(cur_orig));
                chk("isect_inv_dir", 128'(isect_inv_dir), 128'(cur_dir));
            end
            if (leaf_valid && leaf_ready) begin
                if (exp_leaf.size() == 0) chk("unexpected_leaf", 128'(leaf_prim), 128'(0) - 1);
                else chk("leaf_record", 128'({leaf_prim, leaf_range}), 128'(exp_leaf.pop_front()));
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 128'(nodes_visited), 128'(0) - 1);
                else chk("done_ovf_visited", 128'({overflow, nodes_visited}), 128'(exp_done.pop_front()));
            end
            stalled  = leaf_valid && !leaf_ready;
            st_prim  = leaf_prim;
            st_range = leaf_range;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ray_ready"}, 128'(ray_ready), 128'(1));
        chk({tag, "_rd_en"}, 128'(node_rd_en), 128'(0));
        chk({tag, "_addr"}, 128'(node_addr), 128'(0));
        chk({tag, "_leaf_valid"}, 128'(leaf_valid), 128'(0));
        chk({tag, "_leaf_data"}, 128'({leaf_prim, leaf_range}), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_ovf_cnt"}, 128'({overflow, nodes_visited}), 128'(0));
        chk({tag, "_isect_ray"}, 128'({isect_orig, isect_range}), 128'(0));
    endtask

    initial begin
        int w;
        for (int i = 0; i < NMEM; i++) set_node(i, 1'b1, 0, 1'b0);
        #12;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Root leaf hit: read at first cycle, leaf two cycles later
        set_node(0, 1'b1, 5, 1'b1);
        send_ray({24'h100000, 24'h000000});
        @(negedge clk);
        chk("t1_rd_en", 128'({node_rd_en, node_addr}), 128'({1'b1, 10'd0}));
        @(negedge clk);
        @(negedge clk);
        chk("t1_leaf_valid", 128'(leaf_valid), 128'(1));
        wait_done();

        // Root miss
        set_node(0, 1'b0, 1, 1'b0);
        send_ray({24'h000300, 24'h000010});
        wait_done();

        // Inner root, left misses, right leaf prim 7
        set_node(0, 1'b0, 1, 1'b1);
        set_node(1, 1'b1, 9, 1'b0);
        set_node(2, 1'b1, 7, 1'b1);
        send_ray({$urandom, $urandom}[47:0]);
        wait_done();

        // Left-descending chain deeper than the stack
        for (int i = 0; i < 6; i++) begin
            set_node((i == 0) ? 0 : 2 * i - 1, 1'b0, 2 * i + 1, 1'b1);
            set_node(2 * i + 2, 1'b1, 40 + i, 1'b0);
        end
        set_node(11, 1'b1, 3, 1'b1);
        send_ray(48'h0000ff_000001);
        wait_done();

        // Downstream stalls for five cycles on a leaf
        set_node(0, 1'b1, 21, 1'b1);
        hold_low = 100000;
        send_ray(48'h123456_654321);
        w = 0;
        while (!leaf_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("t5_leaf_seen", 128'(leaf_valid), 128'(1));
        hold_low = 4;
        wait_done();

        // Asynchronous reset while testing a node mid-tree
        set_node(0, 1'b0, 1, 1'b1);
        set_node(1, 1'b0, 3, 1'b1);
        set_node(3, 1'b1, 2, 1'b1);
        set_node(4, 1'b1, 6, 1'b1);
        set_node(2, 1'b1, 8, 1'b1);
        send_ray(48'h0a0b0c_0d0e0f);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t6_second_read", 128'({node_rd_en, node_addr}), 128'({1'b1, 10'd1}));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        exp_addr.delete();
        exp_leaf.delete();
        exp_done.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", 128'(ray_ready), 128'(1));
        repeat (4) @(negedge clk);
        chk("t6_no_done", 128'(done), 128'(0));
        send_ray(48'h0a0b0c_0d0e0f);
        wait_done();

        // Random trees and rays
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 64; i++) set_node(i, 1'b1, 0, 1'b0);
            gen_tree(41);
            send_ray({$urandom, $urandom}[47:0]);
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bvh_traverser.md
Name: bvh_traverser

Overview:
- Sequential initiator that drives the combinational ray/box intersection unit.
- Accepts one ray, walks the BVH depth-first from root node 0, and uses an index stack to do so.
- For each node it issues a node-memory read, presents the node box to the intersector, and consumes the returned hit/range.
- Streams every hit leaf's primitive index and range to the downstream triangle stage, then pulses done.

Parameters:
- NODE_AW, 10, node index/address width.
- STACK_DEPTH, 16, entries in the deferred-node stack (power of 2, ≥2).
- CNT_W, 16, width of nodes_visited counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ray_valid  in  1  ray request valid
- ray_ready  out  1  traverser idle, can accept ray
- ray_orig_in  in  vec3 (72)  ray origin, 3×24-bit fixed point
- inv_dir_in  in  vec3 (72)  reciprocal direction
- t_range_in  in  vec2 (48)  initial [tmin,tmax]
- node_rd_en  out  1  node memory read strobe
- node_addr  out  NODE_AW  node index to read
- node_box  in  bbox (144)  node bounds, valid 1 cycle after node_rd_en
- node_leaf  in  1  node is leaf
- node_child  in  NODE_AW  inner: left child index (right = left+1); leaf: primitive index
- isect_orig  out  vec3  to intersector ray_orig
- isect_inv_dir  out  vec3  to intersector inv_ray_dir
- isect_box  out  bbox  to intersector box
- isect_range  out  vec2  to intersector prev_range
- isect_hit  in  1  intersector hit (combinational, same cycle)
- isect_range_out  in  vec2  intersector clipped range
- leaf_valid  out  1  hit-leaf record valid
- leaf_ready  in  1  downstream accepts record
- leaf_prim  out  NODE_AW  primitive index
- leaf_range  out  vec2  clipped [tmin,tmax] for that leaf
- done  out  1  one-cycle pulse: traversal finished
- overflow  out  1  valid with done; a push was dropped during this ray
- nodes_visited  out  CNT_W  nodes tested for current/last ray

Behaviour:
- Reset (async assert, sync release): state IDLE, ray_ready=1, node_rd_en=0, node_addr=0, leaf_valid=0, leaf_prim=0, leaf_range=0, done=0, overflow=0, nodes_visited=0, stack pointer=0, ray registers=0.
- Reset mid-traversal aborts the ray immediately. No leaf or done is emitted for it.
- States: IDLE, FETCH, TEST, EMIT, DONE.
- IDLE: ray_ready=1. On ray_valid&&ray_ready:
  - register orig/inv_dir/t_range;
  - cur=0, sp=0;
  - clear overflow and nodes_visited;
  - go to FETCH.
- FETCH (1 cycle): node_rd_en=1, node_addr=cur. Go to TEST. Memory latency is fixed at 1 cycle.
- TEST (1 cycle): isect_box=node_box. isect_orig, isect_inv_dir and isect_range are the registered ray values, held constant for the whole ray. nodes_visited increments (saturating). Then:
  - hit & !leaf: push node_child+1, cur=node_child, go to FETCH. If the stack is full, drop the push, set overflow (sticky), and still descend.
  - hit & leaf: capture leaf_prim=node_child and leaf_range=isect_range_out, go to EMIT.
  - miss: if sp>0, pop into cur and go to FETCH; else go to DONE.
- EMIT: leaf_valid=1, with leaf_prim and leaf_range stable until the handshake. On leaf_ready: leaf_valid=0 next cycle, then pop into cur → FETCH, or sp==0 → DONE.
- DONE: done=1 for exactly one cycle. overflow and nodes_visited remain readable until the next ray is accepted. Next state is IDLE.
- Minimum cost: 2 cycles per node visited, plus ≥1 cycle per emitted leaf.
- Stack:
  - LIFO, sp range 0..STACK_DEPTH.
  - Push and pop never coincide.
  - Pop with sp==0 never occurs; it is routed to DONE instead.
- Widths: the right-child index wraps modulo 2^NODE_AW. Range values pass through unmodified; there is no arithmetic on t.
- ray_valid is ignored in every state other than IDLE.
- isect_* outputs remain driven in all states; they are only meaningful in TEST.

Test Plan:
- Root leaf (node_leaf=1, child=5) whose box contains the ray, t_range=[0,0x100000] → node_rd_en at cycle 1 with addr 0; leaf_valid at cycle 3 with prim=5 and range=isect_range_out; done one cycle after leaf_ready; nodes_visited=1.
- Ray misses root → no leaf_valid, done 2 cycles after accept, overflow=0, nodes_visited=1.
- Root inner (child=1): node 1 misses, node 2 is a leaf hit with prim 7 → reads of addr 0,1,2 in order; one leaf record with prim=7; nodes_visited=3.
- STACK_DEPTH=2 with a 4-level left-descending chain → third push dropped; done with overflow=1; traversal terminates with no hang.
- leaf_ready held low 5 cycles on a leaf → leaf_valid, prim and range stable for all 5 cycles; exactly one transfer; no node reads during the stall.
- rst_n asserted while in TEST mid-tree → outputs at reset values asynchronously; no done pulse; ray_ready=1 after release; next ray traverses correctly from root.
